// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and instruction-word output of the
// instruction encoder, each side a valid/ready handshake.
//   in_valid/in_ready   : field bundle handshake (fmt, opcode, funct3, funct7,
//                         rd, rs1, rs2, imm)
//   out_valid/out_ready : encoded word handshake (out_word, out_addr)
// master = producer of fields / consumer of words, slave = the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs range-checked RV32I instruction fields into 32-bit
// instruction words and streams them out with an auto-incrementing word address.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : one-cycle pulse; clears address/counters, drops any pending
//                word and enters RUN
//   bus        : instr_encoder_if.slave (field bundle in, encoded word out)
//   err        : one-cycle pulse the cycle after an illegal bundle is consumed
//   err_count  : saturating count of rejected bundles
//   full       : DEPTH words have been handed to the consumer
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              full
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // Pointer is one bit wider than the address so it can reach DEPTH itself.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_r;
  logic [ADDR_W:0]   ptr_r;
  logic              out_valid_r;
  logic [31:0]       out_word_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              err_r;
  logic [7:0]        err_count_r;
  logic              full_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              legal_s;
  logic              out_hs_s;
  logic [31:0]       word_s;

  // Standard RV32I field placement for each format.
  function automatic logic [31:0] pack_word(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] im
  );
    logic [31:0] w;
    case (f)
      3'd0:    w = {f7, s2, s1, f3, d, op};
      3'd1:    w = {im[11:0], s1, f3, d, op};
      3'd2:    w = {im[11:5], s2, s1, f3, im[4:0], op};
      3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      3'd4:    w = {im[31:12], d, op};
      3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, op};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // An immediate is legal only if the packed word reproduces it exactly.
  function automatic logic is_legal(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [31:0] im
  );
    logic signed [31:0] s;
    logic               ok;
    s = $signed(im);
    case (f)
      3'd0:       ok = 1'b1;
      3'd1, 3'd2: ok = (s >= -32'sd2048) && (s <= 32'sd2047);
      3'd3:       ok = (s >= -32'sd4096) && (s <= 32'sd4094) && (im[0] == 1'b0);
      3'd4:       ok = (im[11:0] == 12'h000);
      3'd5:       ok = (s >= -32'sd1048576) && (s <= 32'sd1048574) && (im[0] == 1'b0);
      default:    ok = 1'b0;
    endcase
    return ok && (op[1:0] == 2'b11);
  endfunction

  // Input acceptance: only in RUN, not during start, with room in the output
  // register and while the word budget is not exhausted.
  always_comb begin
    in_ready_s = (state_r == ST_RUN) && !start && (!out_valid_r || bus.out_ready)
                 && (ptr_r < DEPTH_C);
    accept_s   = bus.in_valid && in_ready_s;
    out_hs_s   = out_valid_r && bus.out_ready;
    legal_s    = is_legal(bus.fmt, bus.opcode, bus.imm);
    word_s     = pack_word(bus.fmt, bus.opcode, bus.funct3, bus.funct7,
                           bus.rd, bus.rs1, bus.rs2, bus.imm);
  end

  // Mode FSM, write pointer and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      full_r  <= 1'b0;
    end else if (start) begin
      state_r <= ST_RUN;
      ptr_r   <= '0;
      full_r  <= 1'b0;
    end else begin
      if (accept_s && legal_s) begin
        ptr_r <= ptr_r + 1'b1;
      end
      // With the pointer at DEPTH the pending word must be the last one.
      if ((state_r == ST_RUN) && out_hs_s && (ptr_r == DEPTH_C)) begin
        state_r <= ST_FULL;
        full_r  <= 1'b1;
      end
    end
  end

  // Output word register: loads on a legal accept, clears on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_word_r  <= 32'h0000_0000;
      out_addr_r  <= '0;
    end else if (start) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= legal_s;
      if (legal_s) begin
        out_word_r <= word_s;
        out_addr_r <= ptr_r[ADDR_W-1:0];
      end
    end else if (out_hs_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Reject pulse and saturating reject counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r       <= 1'b0;
      err_count_r <= 8'd0;
    end else if (start) begin
      err_r       <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      err_r <= accept_s && !legal_s;
      if (accept_s && !legal_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_word  = out_word_r;
  assign bus.out_addr  = out_addr_r;
  assign err           = err_r;
  assign err_count     = err_count_r;
  assign full          = full_r;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder (DEPTH=4, ADDR_W=3).
module tb_instr_encoder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       err;
  logic [7:0] err_count;
  logic       full;
  int         checks;
  int         errors;

  instr_encoder_if #(.ADDR_W(3)) bus ();

  instr_encoder #(.ADDR_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .err       (err),
    .err_count (err_count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [31:0] im);
    bus.fmt    = f;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rd     = d;
    bus.rs1    = s1;
    bus.rs2    = s2;
    bus.imm    = im;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w, input logic [31:0] a);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_word"}, bus.out_word, w);
    check({tag, "_addr"}, {29'd0, bus.out_addr}, a);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_fields(3'd0, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) tick();

    // Reset state
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_addr", {29'd0, bus.out_addr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores bundles
    bus.in_valid = 1'b1;
    #1 check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("idle_no_out", {31'd0, bus.out_valid}, 32'd0);
    check("idle_no_err", {31'd0, err}, 32'd0);

    // R format
    pulse_start();
    #1 check("run_in_ready", {31'd0, bus.in_ready}, 32'd1);
    set_fields(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    expect_word("r_add", 32'h0020_81B3, 32'd0);
    tick();
    check("r_drain", {31'd0, bus.out_valid}, 32'd0);

    // I then S back-to-back
    pulse_start();
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    bus.in_valid = 1'b1;
    tick();
    expect_word("i_addi", 32'hFFF0_0293, 32'd0);
    set_fields(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    bus.in_valid = 1'b0;
    expect_word("s_sw", 32'h0020_A423, 32'd1);
    tick();

    // B, U, J consecutive
    pulse_start();
    set_fields(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    bus.in_valid = 1'b1;
    tick();
    expect_word("b_beq", 32'hFE00_0EE3, 32'd0);
    set_fields(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
    tick();
    expect_word("u_lui", 32'h1234_50B7, 32'd1);
    set_fields(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    bus.in_valid = 1'b0;
    expect_word("j_jal", 32'h0010_00EF, 32'd2);
    tick();

    // Rejected bundles
    pulse_start();
    bus.in_valid = 1'b1;
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048);
    tick();
    check("e1_err", {31'd0, err}, 32'd1);
    check("e1_no_out", {31'd0, bus.out_valid}, 32'd0);
    check("e1_cnt", {24'd0, err_count}, 32'd1);
    set_fields(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    tick();
    check("e2_err", {31'd0, err}, 32'd1);
    check("e2_cnt", {24'd0, err_count}, 32'd2);
    set_fields(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1001);
    tick();
    check("e3_err", {31'd0, err}, 32'd1);
    check("e3_cnt", {24'd0, err_count}, 32'd3);
    set_fields(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    check("e4_err", {31'd0, err}, 32'd1);
    check("e4_no_out", {31'd0, bus.out_valid}, 32'd0);
    check("e4_cnt", {24'd0, err_count}, 32'd4);
    set_fields(3'd0, 7'h30, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("e5_opcode_err", {31'd0, err}, 32'd1);
    check("e5_cnt", {24'd0, err_count}, 32'd5);
    tick();
    check("e_err_pulse_end", {31'd0, err}, 32'd0);
    check("e_cnt_hold", {24'd0, err_count}, 32'd5);
    set_fields(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    expect_word("e_ptr_kept", 32'h0020_81B3, 32'd0);
    tick();

    // Backpressure
    pulse_start();
    bus.out_ready = 1'b0;
    set_fields(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    tick();
    expect_word("bp_first", 32'h0020_81B3, 32'd0);
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      expect_word("bp_hold", 32'h0020_81B3, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    expect_word("bp_next", 32'hFFF0_0293, 32'd1);
    tick();
    check("bp_drain", {31'd0, bus.out_valid}, 32'd0);

    // Fill to DEPTH
    pulse_start();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_fields(3'd0, 7'h33, 3'd0, 7'd0, 5'(i), 5'd1, 5'd2, 32'd0);
      tick();
      expect_word("fill", 32'h0020_8033 | (32'(i) << 7), 32'(i));
    end
    #1 check("fill_ready_low", {31'd0, bus.in_ready}, 32'd0);
    check("fill_not_full_yet", {31'd0, full}, 32'd0);
    tick();
    check("full_set", {31'd0, full}, 32'd1);
    check("full_out_idle", {31'd0, bus.out_valid}, 32'd0);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("full_ignore_err", {31'd0, err}, 32'd0);
    check("full_ignore_out", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;
    pulse_start();
    check("restart_full_clr", {31'd0, full}, 32'd0);
    set_fields(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    expect_word("restart_addr0", 32'h0020_81B3, 32'd0);
    tick();

    // Async reset mid-stream
    bus.in_valid = 1'b1;
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048);
    tick();
    bus.out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    bus.in_valid = 1'b0;
    expect_word("pre_rst", 32'hFFF0_0293, 32'd1);
    check("pre_rst_cnt", {24'd0, err_count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_out_word", bus.out_word, 32'd0);
    check("arst_out_addr", {29'd0, bus.out_addr}, 32'd0);
    check("arst_err_count", {24'd0, err_count}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("arst_full", {31'd0, full}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
